// File: rtl/store_buffer_if.sv
// Bundles the pipeline store/load handshakes and the cache wr_req/rd_req handshakes.
// slave is the store buffer's view; master is the surrounding pipeline/cache view.
interface store_buffer_if #(
   parameter int PTR_W = 2
);
   logic             st_valid;
   logic             st_ready;
   logic [31:0]      st_address;
   logic [63:0]      st_data;
   logic             st_size;
   logic             ld_valid;
   logic             ld_ready;
   logic [31:0]      ld_address;
   logic             wr_req_valid;
   logic             wr_req_ready;
   logic [31:0]      wr_req_address;
   logic [63:0]      wr_req_data;
   logic             wr_size;
   logic             rd_req_valid;
   logic             rd_req_ready;
   logic [31:0]      rd_req_address;
   logic             sb_empty;
   logic [PTR_W:0]   sb_count;

   modport slave (
      input  st_valid, st_address, st_data, st_size,
      input  ld_valid, ld_address,
      input  wr_req_ready, rd_req_ready,
      output st_ready, ld_ready,
      output wr_req_valid, wr_req_address, wr_req_data, wr_size,
      output rd_req_valid, rd_req_address,
      output sb_empty, sb_count
   );

   modport master (
      output st_valid, st_address, st_data, st_size,
      output ld_valid, ld_address,
      output wr_req_ready, rd_req_ready,
      input  st_ready, ld_ready,
      input  wr_req_valid, wr_req_address, wr_req_data, wr_size,
      input  rd_req_valid, rd_req_address,
      input  sb_empty, sb_count
   );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO feeding cache writes; one-cycle min store->wr_req latency, no bypass.
// st_ready drops only on registered full; loads touching a buffered/same-cycle store block stall.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic         clk,
   input  logic         reset,
   store_buffer_if.slave bus
);

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
      logic        size;
   } entry_t;

   entry_t             ent_q   [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;

   logic               push, pop, conflict;
   logic [28:0]        ld_blk, ld_blk2;

   // A 64-bit store that is not 8-byte aligned also touches the next block.
   function automatic logic blk_hit(input logic [31:0] addr, input logic size,
                                    input logic [28:0] b0, input logic [28:0] b1);
      logic [28:0] e0, e1;
      logic        span;
      e0   = addr[31:3];
      e1   = addr[31:3] + 29'd1;
      span = size & (addr[2:0] != 3'd0);
      return (e0 == b0) | (e0 == b1) | (span & ((e1 == b0) | (e1 == b1)));
   endfunction

   assign bus.st_ready       = (count_q != (PTR_W+1)'(DEPTH));
   assign bus.wr_req_valid   = valid_q[head_q];
   assign bus.wr_req_address = ent_q[head_q].addr;
   assign bus.wr_req_data    = ent_q[head_q].data;
   assign bus.wr_size        = ent_q[head_q].size;
   assign bus.sb_empty       = (count_q == '0);
   assign bus.sb_count       = count_q;

   assign push = bus.st_valid & bus.st_ready;
   assign pop  = bus.wr_req_valid & bus.wr_req_ready;

   assign ld_blk  = bus.ld_address[31:3];
   assign ld_blk2 = bus.ld_address[31:3] + 29'd1;

   always_comb begin
      conflict = bus.st_valid & blk_hit(bus.st_address, bus.st_size, ld_blk, ld_blk2);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && blk_hit(ent_q[i].addr, ent_q[i].size, ld_blk, ld_blk2))
            conflict = 1'b1;
      end
   end

   assign bus.rd_req_valid   = bus.ld_valid & ~conflict;
   assign bus.ld_ready       = bus.rd_req_ready & ~conflict;
   assign bus.rd_req_address = bus.ld_address;

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) begin
            ent_q[tail_q].addr <= bus.st_address;
            ent_q[tail_q].data <= bus.st_data;
            ent_q[tail_q].size <= bus.st_size;
         end
      end
   end

endmodule
